// File: rtl/hist_bin_reader.sv
// Histogram bin reader: debounced KEY steps through bins, reads each count and converts it to 4 BCD digits.
// Optional build macro HIST_AUTO_SCAN_EN adds a periodic auto-step timer.
module hist_bin_reader #(
    parameter int unsigned NUM_BINS     = 11,
    parameter int unsigned DATA_W       = 14,
    parameter int unsigned DEBOUNCE_CYC = 500000,
`ifdef HIST_AUTO_SCAN_EN
    parameter int unsigned AUTO_CYC     = 50000000,
`endif
    parameter int unsigned REFRESH_CYC  = 2500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_n,
    output logic [3:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [3:0]        bin_idx,
    output logic [3:0]        digit0,
    output logic [3:0]        digit1,
    output logic [3:0]        digit2,
    output logic [3:0]        digit3,
    output logic              valid,
    output logic              upd,
    output logic              busy,
    output logic              ovf
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned REF_W = $clog2(REFRESH_CYC + 1);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned SR_W  = 16 + DATA_W;

    typedef enum logic [2:0] {IDLE, READ, CAPT, CONV, DONE} state_t;

    logic [1:0]       sync;
    logic             db_level;
    logic [DB_W-1:0]  db_cnt;
    logic             step_pulse;
    logic             auto_step;
    logic             step_evt;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_tick;
    logic             pend_step;
    logic             pend_ref;
    logic             init_pend;
    logic             do_step;
    logic             do_trig;
    logic             accept;
    logic [3:0]       next_idx;
    state_t           state;
    logic [3:0]       tgt_idx;
    logic [SR_W-1:0]  sr;
    logic [CNT_W-1:0] bit_cnt;
    logic             big;

    // Synchronize the key, accept a level only after DEBOUNCE_CYC identical samples, pulse on press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= 2'b11;
            db_level   <= 1'b1;
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync       <= {sync[0], step_n};
            step_pulse <= 1'b0;
            if (sync[1] != db_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_level   <= sync[1];
                    db_cnt     <= '0;
                    step_pulse <= db_level;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

`ifdef HIST_AUTO_SCAN_EN
    localparam int unsigned AUTO_W = $clog2(AUTO_CYC + 1);
    logic [AUTO_W-1:0] auto_cnt;

    // Periodic auto-advance; a manual press restarts the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt  <= '0;
            auto_step <= 1'b0;
        end else begin
            auto_step <= 1'b0;
            if (step_pulse) begin
                auto_cnt <= '0;
            end else if (auto_cnt == AUTO_W'(AUTO_CYC - 1)) begin
                auto_cnt  <= '0;
                auto_step <= 1'b1;
            end else begin
                auto_cnt <= auto_cnt + AUTO_W'(1);
            end
        end
    end
`else
    assign auto_step = 1'b0;
`endif

    assign step_evt = step_pulse | auto_step;
    assign ref_tick = (ref_cnt == REF_W'(REFRESH_CYC - 1));
    assign do_step  = step_evt | pend_step;
    assign do_trig  = do_step | ref_tick | pend_ref | init_pend;
    assign accept   = (state == IDLE) && do_trig;
    assign next_idx = !do_step ? bin_idx :
                      (bin_idx == 4'(NUM_BINS - 1)) ? 4'd0 : bin_idx + 4'd1;

    // Refresh timer restarts whenever a trigger is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
        end else if (accept || ref_tick) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[DATA_W + 4*i +: 4] >= 4'd5) begin
                r[DATA_W + 4*i +: 4] = r[DATA_W + 4*i +: 4] + 4'd3;
            end
        end
        return r << 1;
    endfunction

    // Read/convert sequencer; display registers change only in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr   <= '0;
            bin_idx   <= '0;
            digit0    <= '0;
            digit1    <= '0;
            digit2    <= '0;
            digit3    <= '0;
            valid     <= 1'b0;
            upd       <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            tgt_idx   <= '0;
            sr        <= '0;
            bit_cnt   <= '0;
            big       <= 1'b0;
            pend_step <= 1'b0;
            pend_ref  <= 1'b0;
            init_pend <= 1'b1;
        end else begin
            upd <= 1'b0;
            if (state != IDLE) begin
                if (step_evt) pend_step <= 1'b1;
                if (ref_tick) pend_ref  <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (do_trig) begin
                        rd_addr   <= next_idx;
                        tgt_idx   <= next_idx;
                        pend_step <= 1'b0;
                        pend_ref  <= 1'b0;
                        init_pend <= 1'b0;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: state <= CAPT;
                CAPT: begin
                    sr      <= {16'd0, rd_data};
                    big     <= 32'(rd_data) > 32'd9999;
                    bit_cnt <= '0;
                    state   <= CONV;
                end
                CONV: begin
                    sr      <= dabble(sr);
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) state <= DONE;
                end
                DONE: begin
                    bin_idx <= tgt_idx;
                    if (big) begin
                        digit0 <= 4'd9;
                        digit1 <= 4'd9;
                        digit2 <= 4'd9;
                        digit3 <= 4'd9;
                    end else begin
                        digit0 <= sr[DATA_W      +: 4];
                        digit1 <= sr[DATA_W + 4  +: 4];
                        digit2 <= sr[DATA_W + 8  +: 4];
                        digit3 <= sr[DATA_W + 12 +: 4];
                    end
                    ovf   <= big;
                    valid <= 1'b1;
                    upd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_bin_reader.sv
// Bench for hist_bin_reader: directed key presses against a bin RAM model, upd events checked via a scoreboard.
module tb_hist_bin_reader;

    localparam int unsigned DATA_W = 14;

    typedef struct packed {
        logic [3:0]  idx;
        logic [3:0]  addr;
        logic [15:0] dig;
        logic        ovf;
        logic        valid;
    } snap_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              step_n = 1'b1;
    logic [3:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        bin_idx, digit0, digit1, digit2, digit3;
    logic              valid, upd, busy, ovf;

    logic [DATA_W-1:0] mem [16];
    snap_t             obs_q[$];
    int                exp_q[$];
    int                cur_idx;
    int                n_cmp = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    hist_bin_reader #(
        .NUM_BINS(11), .DATA_W(DATA_W), .DEBOUNCE_CYC(4),
`ifdef HIST_AUTO_SCAN_EN
        .AUTO_CYC(256),
`endif
        .REFRESH_CYC(64)
    ) dut (
        .clk(clk), .rst(rst), .step_n(step_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .bin_idx(bin_idx), .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .valid(valid), .upd(upd), .busy(busy), .ovf(ovf)
    );

    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (!rst && upd) obs_q.push_back('{bin_idx, rd_addr, {digit3, digit2, digit1, digit0}, ovf, valid});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int next_of(input int i);
        return (i == 10) ? 0 : i + 1;
    endfunction

    // Each upd either completes the oldest expected bin or is a refresh of the current bin.
    task automatic drain();
        snap_t s;
        int    v;
        while (obs_q.size() > 0) begin
            s = obs_q.pop_front();
            if (exp_q.size() > 0 && int'(s.idx) == exp_q[0]) cur_idx = exp_q.pop_front();
            v = int'(mem[cur_idx]);
            chk("upd_bin_idx", s.idx, cur_idx);
            chk("upd_rd_addr", s.addr, cur_idx);
            chk("upd_digits", s.dig, bcd_of(v));
            chk("upd_ovf", s.ovf, (v > 9999) ? 1 : 0);
            chk("upd_valid", s.valid, 1);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        drain();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("scoreboard_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic press(input int lo, input int hi);
        step_n = 1'b0;
        repeat (lo) cyc();
        step_n = 1'b1;
        repeat (hi) cyc();
    endtask

    task automatic step_and_check();
        exp_q.push_back(next_of(exp_q.size() > 0 ? exp_q[$] : cur_idx));
        press(10, 8);
        wait_done(120);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_bin_idx"}, bin_idx, 0);
        chk({tag, "_digits"}, {digit3, digit2, digit1, digit0}, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_upd"}, upd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        int lat;
        for (int k = 0; k < 16; k++) mem[k] = DATA_W'(100 + 7 * k);
        mem[0] = 14'd37;
        mem[1] = 14'd1234;
        mem[2] = 14'd12000;
        mem[3] = 14'd5;
        cur_idx = 0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // First read of bin 0 starts right after release; upd 17 cycles after that trigger.
        rst = 1'b0;
        exp_q.push_back(0);
        lat = 0;
        do begin
            cyc();
            lat++;
            if (lat == 1) begin
                chk("first_busy", busy, 1);
                chk("first_rd_addr", rd_addr, 0);
            end
        end while (!upd && lat < 40);
        chk("first_upd_latency", lat, 18);
        wait_done(10);

        step_and_check();
        chk("step_bin1_idx", bin_idx, 1);

        step_n = 1'b0;
        repeat (2) cyc();
        step_n = 1'b1;
        repeat (40) cyc();
        chk("glitch_no_change", bin_idx, 1);

        step_and_check();
        chk("ovf_bin2", ovf, 1);
        step_and_check();
        chk("ovf_cleared_bin3", ovf, 0);

        while (cur_idx != 10) step_and_check();
        for (int i = 0; i < 11; i++) step_and_check();
        chk("wrap_end_idx", bin_idx, 10);

        // Three quick presses: first starts a read, second is held pending, third is dropped.
        exp_q.push_back(next_of(cur_idx));
        exp_q.push_back(next_of(next_of(cur_idx)));
        press(4, 4);
        press(4, 4);
        press(4, 4);
        wait_done(120);
        repeat (30) cyc();
        chk("triple_step_idx", bin_idx, 1);

        // Reset in the middle of a conversion.
        exp_q.push_back(next_of(cur_idx));
        step_n = 1'b0;
        repeat (10) cyc();
        step_n = 1'b1;
        repeat (3) cyc();
        chk("midconv_busy", busy, 1);
        rst = 1'b1;
        #2;
        check_reset_outputs("midconv_reset");
        exp_q.delete();
        obs_q.delete();
        cur_idx = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(0);
        wait_done(60);

        // Live count change is picked up by refresh; index stays put without key presses.
        mem[0] = 14'd4321;
        repeat (300) cyc();
        chk("refresh_digits", {digit3, digit2, digit1, digit0}, 16'h4321);
        chk("static_idx", bin_idx, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
